// File: rtl/vram_window_server.sv
// vram_window_server: fetches 5x5 byte windows from SRAM and buffers accelerator writes in a 4-deep FIFO
module vram_window_server (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [23:0]  daddr,
  input  logic [15:0]  image_size,
  output logic [199:0] drdata,
  output logic         rsp_valid,
  input  logic         dwe,
  input  logic [23:0]  destination_addr,
  input  logic [7:0]   dwdata,
  output logic         wr_overflow,
  output logic [23:0]  mem_addr,
  output logic         mem_re,
  output logic         mem_we,
  output logic [7:0]   mem_wdata,
  input  logic [7:0]   mem_rdata
);
  typedef enum logic [1:0] {IDLE, FETCH, RESP} state_t;
  state_t state, state_n;
  logic [23:0] row_base;
  logic [15:0] stride;
  logic [2:0] col;
  logic [4:0] k, cap_k;
  logic cap_v;
  logic [31:0] fifo [4];
  logic [1:0] wp, rp;
  logic [2:0] cnt;
  logic accept, pop, push;
  // k runs one past the last read so the final capture lands before RESP
  always_comb begin
    req_ready = state == IDLE && cnt == 3'd0;
    accept = req_valid && req_ready;
    pop = state == IDLE && cnt != 3'd0;
    push = dwe && (cnt != 3'd4 || pop);
    mem_re = state == FETCH && k != 5'd25;
    mem_we = pop;
    mem_addr = mem_re ? row_base + 24'(col) : mem_we ? fifo[rp][31:8] : 24'd0;
    mem_wdata = mem_we ? fifo[rp][7:0] : 8'd0;
    rsp_valid = state == RESP;
    state_n = accept ? FETCH : (state == FETCH && k == 5'd25) ? RESP : state == RESP ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      row_base <= 24'd0;
      stride <= 16'd0;
      col <= 3'd0;
      k <= 5'd0;
      cap_k <= 5'd0;
      cap_v <= 1'b0;
      drdata <= '0;
      wp <= 2'd0;
      rp <= 2'd0;
      cnt <= 3'd0;
      wr_overflow <= 1'b0;
    end else begin
      state <= state_n;
      cap_v <= mem_re;
      cap_k <= k;
      if (cap_v) drdata[{cap_k, 3'b000} +: 8] <= mem_rdata;
      if (accept) begin
        row_base <= daddr;
        stride <= image_size;
        col <= 3'd0;
        k <= 5'd0;
      end else if (mem_re) begin
        k <= k + 5'd1;
        col <= col == 3'd4 ? 3'd0 : col + 3'd1;
        if (col == 3'd4) row_base <= row_base + 24'(stride);
      end
      if (push) begin
        fifo[wp] <= {destination_addr, dwdata};
        wp <= wp + 2'd1;
      end
      if (pop) rp <= rp + 2'd1;
      cnt <= cnt + {2'b00, push} - {2'b00, pop};
      if (dwe && !push) wr_overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_vram_window_server.sv
// tb_vram_window_server: randomized and directed scoreboard bench against a transaction-level model
module tb_vram_window_server;
  logic clk = 1'b0;
  logic reset, req_valid, dwe, req_ready, rsp_valid, wr_overflow, mem_re, mem_we;
  logic [23:0] daddr, destination_addr, mem_addr;
  logic [15:0] image_size;
  logic [7:0] dwdata, mem_wdata, mem_rdata;
  logic [199:0] drdata;
  bit mem_mode = 1'b0;

  vram_window_server dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .daddr(daddr), .image_size(image_size), .drdata(drdata), .rsp_valid(rsp_valid),
    .dwe(dwe), .destination_addr(destination_addr), .dwdata(dwdata),
    .wr_overflow(wr_overflow), .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] sram(input logic [23:0] a, input bit mode);
    return mode ? (a[7:0] ^ a[15:8] ^ 8'h5A) : a[7:0];
  endfunction

  always @(posedge clk) mem_rdata <= (mem_re === 1'b1) ? sram(mem_addr, mem_mode) : 8'h00;

  typedef struct {int c; logic [23:0] a;} rd_t;
  typedef struct {int c; logic [199:0] d;} rs_t;
  rd_t rq[$];
  rs_t sq[$];
  logic [31:0] wq[$];
  int cyc = 0, busy = 0, occ = 0, flush_seq = 0;
  bit ovf = 1'b0, started = 1'b0;

  // Model: busy counts the 27 non-idle cycles after an accept; occ is FIFO occupancy
  initial forever begin
    @(posedge clk);
    if (reset) begin
      busy = 0;
      occ = 0;
      ovf = 1'b0;
      flush_seq++;
      started = 1'b1;
    end else if (started) begin
      bit idle, pop, acc;
      logic [23:0] a;
      logic [199:0] w;
      idle = busy == 0;
      pop = idle && occ > 0;
      acc = req_valid && idle && occ == 0;
      if (dwe) begin
        if (occ < 4 || pop) begin
          wq.push_back({destination_addr, dwdata});
          occ++;
        end else ovf = 1'b1;
      end
      if (pop) occ--;
      if (busy > 0) busy--;
      if (acc) begin
        busy = 27;
        w = '0;
        for (int k = 0; k < 25; k++) begin
          a = 24'(int'(daddr) + (k / 5) * int'(image_size) + k % 5);
          rq.push_back('{cyc + 1 + k, a});
          w[8*k +: 8] = sram(a, mem_mode);
        end
        sq.push_back('{cyc + 27, w});
      end
    end
    cyc++;
  end

  int errors = 0, checks = 0, n_rsp = 0, ri = 0, si = 0, wi = 0, seen = 0;
  logic [199:0] last_win = '0;

  task automatic chk(input string nm, input logic [199:0] act, input logic [199:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  initial forever begin
    bit exp_re, exp_rsp;
    @(negedge clk);
    if (seen != flush_seq) begin
      ri = rq.size();
      si = sq.size();
      wi = wq.size();
      seen = flush_seq;
    end
    if (started) begin
      chk("req_ready", req_ready, busy == 0 && occ == 0);
      exp_re = ri < rq.size() && rq[ri].c == cyc;
      chk("mem_re", mem_re, exp_re);
      if (exp_re) begin
        if (mem_re) chk("rd_addr", mem_addr, rq[ri].a);
        ri++;
      end
      chk("mem_we", mem_we, busy == 0 && occ > 0);
      if (mem_we === 1'b1) begin
        if (wi < wq.size()) begin
          chk("wr_addr", mem_addr, wq[wi][31:8]);
          chk("wr_data", mem_wdata, wq[wi][7:0]);
          wi++;
        end else chk("wr_unexpected", mem_we, 0);
      end
      exp_rsp = si < sq.size() && sq[si].c == cyc;
      chk("rsp_valid", rsp_valid, exp_rsp);
      if (exp_rsp) begin
        if (rsp_valid) begin
          chk("drdata", drdata, sq[si].d);
          last_win = drdata;
          n_rsp++;
        end
        si++;
      end
      chk("wr_overflow", wr_overflow, ovf);
      chk("re_we_excl", mem_re && mem_we, 0);
      if (mem_re === 1'b0 && mem_we === 1'b0) chk("idle_bus", {mem_addr, mem_wdata}, 0);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_rsp();
    int n0 = n_rsp;
    for (int i = 0; i < 60 && n_rsp == n0; i++) tick();
    chk("rsp_timeout", n_rsp > n0, 1);
  endtask

  initial begin
    int w0, nr;
    reset = 1'b1; req_valid = 1'b0; dwe = 1'b0; daddr = '0; image_size = '0;
    destination_addr = '0; dwdata = '0;
    tick(2);
    reset = 1'b0;
    chk("rst_drdata", drdata, 0);
    chk("rst_ready", req_ready, 1);
    daddr = 24'd0; image_size = 16'd200; req_valid = 1'b1;
    tick();
    req_valid = 1'b0; daddr = 24'h123456; image_size = 16'd7;
    wait_rsp();
    chk("basic_b5", last_win[47:40], 8'hC8);
    chk("basic_b24", last_win[199:192], 8'h24);
    tick(2);
    daddr = 24'hFFFFFE; image_size = 16'd1; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    wait_rsp();
    tick(2);
    dwe = 1'b1; destination_addr = 24'hA000; dwdata = 8'h11;
    tick();
    req_valid = 1'b1; destination_addr = 24'hA001; dwdata = 8'h22;
    tick();
    destination_addr = 24'hA002; dwdata = 8'h33;
    tick();
    dwe = 1'b0;
    tick(2);
    req_valid = 1'b0;
    wait_rsp();
    tick(2);
    w0 = wi;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick(3);
    for (int i = 0; i < 6; i++) begin
      dwe = 1'b1; destination_addr = 24'hB000 + 24'(i); dwdata = 8'h40 + 8'(i);
      tick();
    end
    dwe = 1'b0;
    chk("ovf_set", wr_overflow, 1);
    wait_rsp();
    tick(8);
    chk("ovf_writes", wi - w0, 4);
    nr = n_rsp;
    req_valid = 1'b1; daddr = 24'h000100; image_size = 16'd64;
    tick();
    req_valid = 1'b0;
    tick(9);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_drdata", drdata, 0);
    chk("mid_ready", req_ready, 1);
    tick(30);
    chk("mid_no_rsp", n_rsp, nr);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    wait_rsp();
    mem_mode = 1'b1;
    repeat (600) begin
      req_valid = $urandom_range(0, 3) == 0;
      dwe = $urandom_range(0, 2) == 0;
      daddr = 24'($urandom);
      image_size = 16'($urandom);
      destination_addr = 24'($urandom);
      dwdata = 8'($urandom);
      reset = $urandom_range(0, 199) == 0;
      tick();
    end
    reset = 1'b0; req_valid = 1'b0; dwe = 1'b0;
    tick(40);
    chk("end_reads", ri, rq.size());
    chk("end_rsps", si, sq.size());
    chk("end_writes", wi, wq.size());
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vram_window_server.md
VRAM_WINDOW_SERVER -- requirements
Module: vram_window_server

Interface
REQ-001 The block SHALL have exactly one clock and SHALL use a synchronous, active-high reset; the ports are named clk and reset, and all state changes only on the rising edge of clk.
REQ-002 Ports SHALL be as follows:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- req_valid  in  1  window fetch request
- req_ready  out  1  fetch request accepted when high together with req_valid
- daddr  in  24  top-left byte address of the 5x5 window
- image_size  in  16  row stride in bytes
- drdata  out  200  assembled window
- rsp_valid  out  1  one-cycle pulse: drdata holds a new window
- dwe  in  1  write strobe from the accelerator
- destination_addr  in  24  write byte address
- dwdata  in  8  write byte
- wr_overflow  out  1  sticky flag: a write was dropped
- mem_addr  out  24  byte SRAM address
- mem_re  out  1  SRAM read enable
- mem_we  out  1  SRAM write enable
- mem_wdata  out  8  SRAM write data
- mem_rdata  in  8  SRAM read data, valid one cycle after mem_re

Function
REQ-003 The FSM SHALL have three states: IDLE, FETCH and RESP.
REQ-004 req_ready SHALL be 1 only when the state is IDLE and the write FIFO is empty.
REQ-005 On accept (req_valid && req_ready), the block SHALL latch daddr and image_size and move to FETCH.
REQ-006 In FETCH, the block SHALL issue 25 reads on consecutive cycles, one per cycle, with mem_re=1.
- Index k=0..24; row r=k/5, column c=k%5.
- Address = daddr + r*image_size + c, computed modulo 2^24.
- Implementation: a row base accumulated by adding image_size; no multiplier.
REQ-007 Byte k SHALL be captured into drdata[8k+7:8k] one cycle after its read is issued.
REQ-008 For an accept at cycle T:
- reads are issued at T+1..T+25;
- captures occur at T+2..T+26;
- the state is RESP at T+27, with rsp_valid=1 for that single cycle;
- the state returns to IDLE at T+28.
REQ-009 drdata SHALL hold its value from the end of a fetch until the first capture of the next fetch.
REQ-010 Writes SHALL pass through a 4-entry FIFO. Each entry holds {destination_addr, dwdata}; an entry is pushed on every cycle with dwe=1.
REQ-011 The FIFO SHALL drain one entry per cycle (mem_we=1, mem_addr/mem_wdata from the head) only while the state is IDLE. It SHALL never drain during FETCH or RESP.
REQ-012 Writes SHALL drain in push order.
REQ-013 A push into a full FIFO with no pop in the same cycle SHALL be dropped and SHALL set wr_overflow. wr_overflow stays set until reset.
REQ-014 A push and a pop in the same cycle on a full FIFO SHALL both succeed; occupancy stays at 4.
REQ-015 In IDLE with a non-empty FIFO, writes SHALL take priority over a pending req_valid. A request waits while writes drain.
REQ-016 A push in the same cycle as a request accept SHALL be stored and drained after RESP.
REQ-017 mem_re and mem_we SHALL never both be 1 in the same cycle.
REQ-018 When neither is active, mem_addr and mem_wdata SHALL be 0.
REQ-019 req_valid in FETCH or RESP SHALL be ignored (req_ready=0).
REQ-020 daddr and image_size changing after accept SHALL have no effect on the fetch in progress.

Reset
REQ-021 Reset SHALL force the following, regardless of state, including mid-FETCH:
- state = IDLE;
- FIFO emptied;
- drdata = 0, rsp_valid = 0, wr_overflow = 0;
- mem_re = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0;
- req_ready = 1 in the first cycle after reset deasserts.
REQ-022 A fetch interrupted by reset SHALL NOT produce rsp_valid.

Verification
REQ-023 Basic fetch: SRAM byte at address A = A[7:0], image_size=200, daddr=0, accept at T.
- Reads at addresses 0,1,2,3,4,200,...,804.
- rsp_valid only at T+27.
- drdata byte 5 = 0xC8, byte 24 = 0x24 (804 mod 256).
REQ-024 Wrap: daddr=0xFFFFFE, image_size=1.
- Read addresses are 0xFFFFFE, 0xFFFFFF, 0x000000, ...
- No X values on mem_addr.
REQ-025 Write ordering and priority:
- Push 3 writes (addr 0xA000..0xA002, data 0x11,0x22,0x33) while the state is IDLE.
- Hold req_valid=1 throughout.
- mem_we pulses on 3 cycles in order, then the request is accepted.
REQ-026 Overflow: push 6 consecutive writes during FETCH.
- The first 4 are stored and wr_overflow=1.
- After RESP, exactly 4 writes reach SRAM.
REQ-027 Reset mid-fetch: assert reset at T+10 for 1 cycle.
- rsp_valid never pulses and drdata=0.
- req_ready=1 the next cycle.
- A new fetch then completes normally in 27 cycles.
